ov7670_config_seq: RTL and testbench

OV7670_CONFIG_SEQ -- requirements
Module: ov7670_config_seq

---
 rtl/ov7670_config_seq.sv | 204 ++++++++++++++++++++
 tb/tb_ov7670_config_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_config_seq.sv
// OV7670 SCCB register configuration sequencer.
// Walks a 64-entry {reg,val} table and feeds the bytes to an I2C/SCCB master.
//
// Ports:
//   i_clk     - single clock for all logic
//   i_rst_n   - asynchronous active-low reset
//   i_start   - level; high sample in IDLE/DONE/ERROR starts a pass at entry 0
//   i_ready   - downstream master idle/ready flag
//   o_addr    - 7-bit device address (constant DEV_ADDR)
//   o_din     - byte to transmit; held between transfer requests
//   o_rd_wr   - constant 0 (write only)
//   o_enable  - one-cycle transfer request, only ever asserted in ISSUE
//   o_busy    - pass in progress
//   o_done    - table finished
//   o_error   - master did not respond within TIMEOUT_CYCLES
//   o_index   - current table index
module ov7670_config_seq #(
    parameter logic [6:0]  DEV_ADDR       = 7'h21,
    parameter int unsigned DELAY_CYCLES   = 1000000,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_ready,
    output logic [6:0] o_addr,
    output logic [7:0] o_din,
    output logic       o_rd_wr,
    output logic       o_enable,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic [5:0] o_index
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_DELAY,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [15:0] WORD_EOT   = 16'hFFFF;
    localparam logic [15:0] WORD_DELAY = 16'hF0F0;
    localparam logic [5:0]  LAST_IDX   = 6'd63;

    // Terminal counts: a phase lasting N cycles ends when the counter,
    // cleared on entry, holds N-1.
    localparam logic [31:0] DLY_LAST = 32'(DELAY_CYCLES - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    // Configuration table. Unlisted entries read as end-of-table.
    function automatic logic [15:0] table_word(input logic [5:0] idx);
        logic [15:0] w;
        w = WORD_EOT;
        case (idx)
            6'd0:    w = 16'h1280;  // COM7: soft reset
            6'd1:    w = WORD_DELAY; // let the sensor settle
            6'd2:    w = 16'h1204;  // COM7: RGB output
            6'd3:    w = 16'h40D0;  // COM15: RGB565, full range
            6'd4:    w = 16'h8C00;  // RGB444 off
            6'd5:    w = 16'h1101;  // CLKRC: prescale
            6'd6:    w = WORD_EOT;
            default: w = WORD_EOT;
        endcase
        return w;
    endfunction

    state_e      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic        phase_q, phase_d;  // 0: reg byte, 1: val byte
    logic [7:0]  val_q, val_d;
    logic [7:0]  din_q, din_d;
    logic        enable_c;
    logic [15:0] word_c;

    assign word_c = table_word(idx_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            val_q   <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            val_q   <= val_d;
            din_q   <= din_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        val_d    = val_q;
        din_d    = din_q;
        enable_c = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                if (word_c == WORD_EOT) begin
                    state_d = S_DONE;
                end else if (word_c == WORD_DELAY) begin
                    cnt_d   = '0;
                    state_d = S_DELAY;
                end else begin
                    // din is loaded ahead of ISSUE so the byte is
                    // already stable in the pulse cycle.
                    val_d   = word_c[7:0];
                    din_d   = word_c[15:8];
                    phase_d = 1'b0;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (i_ready) begin
                    enable_c = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_WAIT_BUSY;
                end
            end

            S_WAIT_BUSY: begin
                if (!i_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end else if (cnt_q >= TO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            S_WAIT_DONE: begin
                if (i_ready) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        din_d   = val_q;
                        state_d = S_ISSUE;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = S_FETCH;
                    end
                end else if (cnt_q >= TO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            S_DELAY: begin
                if (cnt_q >= DLY_LAST) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign o_addr   = DEV_ADDR;
    assign o_rd_wr  = 1'b0;
    assign o_din    = din_q;
    assign o_enable = enable_c;
    assign o_index  = idx_q;
    assign o_done   = (state_q == S_DONE);
    assign o_error  = (state_q == S_ERROR);
    assign o_busy   = (state_q != S_IDLE) &&
                      (state_q != S_DONE) &&
                      (state_q != S_ERROR);

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Testbench for ov7670_config_seq: ideal SCCB master model plus a
// scoreboard of expected transfer bytes popped on every o_enable pulse.
module tb_ov7670_config_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mst_ready = 1'b1;
    logic       tb_block = 1'b0;
    logic       ready;
    logic [6:0] o_addr;
    logic [7:0] o_din;
    logic       o_rd_wr;
    logic       o_enable;
    logic       o_busy;
    logic       o_done;
    logic       o_error;
    logic [5:0] o_index;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int n_pulse = 0;
    int hang_at = 0;
    int err_cyc = 0;
    int base = 0;
    logic prev_err = 1'b0;
    int pulse_t[$];
    logic [7:0] exp_q[$];
    logic [7:0] seq [10] = '{8'h12, 8'h80, 8'h12, 8'h04, 8'h40,
                             8'hD0, 8'h8C, 8'h00, 8'h11, 8'h01};

    assign ready = mst_ready & ~tb_block;

    always #5 clk = ~clk;

    ov7670_config_seq #(
        .DEV_ADDR(7'h21),
        .DELAY_CYCLES(10),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_start(start),
        .i_ready(ready),
        .o_addr(o_addr),
        .o_din(o_din),
        .o_rd_wr(o_rd_wr),
        .o_enable(o_enable),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_error(o_error),
        .o_index(o_index)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic kick();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic push_pass(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (k < 3000 && o_done !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(o_done), 1);
    endtask

    task automatic wait_err(input string tag);
        int k = 0;
        while (k < 3000 && o_error !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(o_error), 1);
    endtask

    // Ideal master: ready drops the cycle after a request and comes back
    // 20 cycles later, unless the request is the one chosen to hang.
    initial begin
        forever begin
            @(negedge clk);
            if (o_enable === 1'b1) begin
                @(posedge clk);
                #1 mst_ready = 1'b0;
                repeat (20) @(posedge clk);
                while (hang_at != 0 && n_pulse == hang_at) @(posedge clk);
                #1 mst_ready = 1'b1;
            end
        end
    end

    // Monitor: every request is scored against the expected byte queue.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (o_error === 1'b1 && !prev_err) err_cyc = cyc;
            prev_err = (o_error === 1'b1);
            if (o_enable === 1'b1) begin
                n_pulse++;
                pulse_t.push_back(cyc);
                check("en_addr", 32'(o_addr), 32'h21);
                check("en_rdwr", 32'(o_rd_wr), 0);
                if (exp_q.size() == 0) check("en_spurious", 1, 0);
                else check("en_din", 32'(o_din), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // Reset state
        #12;
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_err", 32'(o_error), 0);
        check("rst_en", 32'(o_enable), 0);
        check("rst_din", 32'(o_din), 0);
        check("rst_addr", 32'(o_addr), 32'h21);
        check("rst_idx", 32'(o_index), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycles(3);
        check("idle_busy", 32'(o_busy), 0);
        check("idle_pulses", n_pulse, 0);

        // Full pass; a second start mid-pass must be ignored
        base = pulse_t.size();
        push_pass(10);
        kick();
        cycles(2);
        check("p1_busy", 32'(o_busy), 1);
        cycles(40);
        kick();
        wait_done("p1_done");
        check("p1_pulses", pulse_t.size() - base, 10);
        check("p1_qempty", exp_q.size(), 0);
        // reg->val: 20 ready-low + WAIT_DONE exit + ISSUE = 22
        check("p1_gap_rv", pulse_t[base+1] - pulse_t[base], 22);
        // val->delay->reg: 22 + FETCH(1) + FETCH(1) + DELAY(10) = 34
        check("p1_gap_dly", pulse_t[base+2] - pulse_t[base+1], 34);
        // val->next reg: 22 + FETCH(1) = 23
        check("p1_gap_ent", pulse_t[base+4] - pulse_t[base+3], 23);
        check("p1_busy_end", 32'(o_busy), 0);
        check("p1_idx_end", 32'(o_index), 6);

        // Restart from DONE
        base = pulse_t.size();
        push_pass(10);
        kick();
        check("p2_idx0", 32'(o_index), 0);
        check("p2_done_clr", 32'(o_done), 0);
        wait_done("p2_done");
        check("p2_pulses", pulse_t.size() - base, 10);

        // Ready held low at ISSUE
        tb_block = 1'b1;
        base = pulse_t.size();
        push_pass(10);
        kick();
        cycles(30);
        check("st_nopulse", pulse_t.size() - base, 0);
        check("st_busy", 32'(o_busy), 1);
        check("st_idx", 32'(o_index), 0);
        tb_block = 1'b0;
        cycles(3);
        check("st_one", pulse_t.size() - base, 1);
        wait_done("st_done");
        check("st_pulses", pulse_t.size() - base, 10);

        // Master hangs on entry 3 (5th request)
        hang_at = n_pulse + 5;
        base = pulse_t.size();
        push_pass(5);
        kick();
        wait_err("to_err");
        // WAIT_BUSY(1) + WAIT_DONE(50) + 1 = 52
        check("to_lat", err_cyc - pulse_t[base+4], 52);
        check("to_idx", 32'(o_index), 3);
        check("to_busy", 32'(o_busy), 0);
        check("to_done", 32'(o_done), 0);
        cycles(20);
        check("to_pulses", pulse_t.size() - base, 5);
        hang_at = 0;
        cycles(5);

        // Restart from ERROR
        base = pulse_t.size();
        push_pass(10);
        kick();
        wait_done("p3_done");
        check("p3_pulses", pulse_t.size() - base, 10);

        // Reset during WAIT_DONE of entry 2
        base = pulse_t.size();
        push_pass(3);
        kick();
        for (int k = 0; k < 2000 && pulse_t.size() - base < 3; k++)
            @(negedge clk);
        check("rs_reach", pulse_t.size() - base, 3);
        cycles(5);
        #2 rst_n = 1'b0;
        #1;
        check("rs_busy", 32'(o_busy), 0);
        check("rs_en", 32'(o_enable), 0);
        check("rs_din", 32'(o_din), 0);
        check("rs_idx", 32'(o_index), 0);
        check("rs_done", 32'(o_done), 0);
        check("rs_err", 32'(o_error), 0);
        cycles(2);
        rst_n = 1'b1;
        cycles(60);
        check("rs_nopulse", pulse_t.size() - base, 3);
        check("rs_qempty", exp_q.size(), 0);
        check("rs_idle", 32'(o_busy), 0);

        // Fresh pass after reset
        base = pulse_t.size();
        push_pass(10);
        kick();
        wait_done("p4_done");
        check("p4_pulses", pulse_t.size() - base, 10);
        check("p4_qempty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
